// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed SRAM model.
// Read and write channels are run by independent FSMs, each with its own
// programmable response latency. Writes honour byte strobes; addresses
// outside [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS) answer SLVERR.
// Ports:
//   clock, reset                     clock, synchronous active-high reset
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel
module axi_lite_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_LAT      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RD_LAT_C = 4'(RD_LAT);
  localparam logic [3:0]  WR_LAT_C = 4'(WR_LAT);
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, ADDR_BASE};
    return (addr >= ADDR_BASE) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return IDX_W'(off >> 2);
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  // ---------------- read channel ----------------
  rd_state_t   r_state_q, r_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs, r_load;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_cnt_d   = RD_LAT_C;
        r_state_d = (RD_LAT_C == '0) ? R_RESP : R_WAIT;
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - 4'd1;
        if (r_cnt_q == 4'd1) r_state_d = R_RESP;
      end
      R_RESP:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // With zero latency the sample happens on the handshake edge itself, so the
  // address comes straight from araddr rather than the latched copy.
  always_comb begin
    ar_hs    = arvalid & arready;
    r_addr_d = ar_hs ? araddr : r_addr_q;
    r_load   = (r_state_d == R_RESP) && (r_state_q != R_RESP);
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (r_load) begin
      if (in_range(r_addr_d)) begin
        rdata_d = mem_q[word_index(r_addr_d)];
        rresp_d = OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = SLVERR;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_t   w_state_q, w_state_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [31:0] aw_addr_q, aw_addr_d, w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs, w_commit, w_ok;
  logic [31:0] w_old, w_merged;

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q | aw_hs;
    w_got_d   = w_got_q | w_hs;
    case (w_state_q)
      W_IDLE: if (aw_got_d && w_got_d) begin
        w_cnt_d   = WR_LAT_C;
        w_state_d = (WR_LAT_C == '0) ? W_RESP : W_WAIT;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
      end
      W_WAIT: begin
        w_cnt_d = w_cnt_q - 4'd1;
        if (w_cnt_q == 4'd1) w_state_d = W_RESP;
      end
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Commit uses the same-cycle handshake values when the second beat and the
  // commit edge coincide (zero latency); otherwise the latched copies.
  always_comb begin
    aw_hs     = awvalid & awready;
    w_hs      = wvalid & wready;
    aw_addr_d = aw_hs ? awaddr : aw_addr_q;
    w_data_d  = w_hs ? wdata : w_data_q;
    w_strb_d  = w_hs ? wstrb : w_strb_q;
    w_commit  = (w_state_d == W_RESP) && (w_state_q != W_RESP);
    w_ok      = in_range(aw_addr_d);
    bresp_d   = w_commit ? (w_ok ? OKAY : SLVERR) : bresp_q;
    w_old     = mem_q[word_index(aw_addr_d)];
    w_merged  = w_old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_strb_d[i]) w_merged[8*i +: 8] = w_data_d[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_commit && w_ok) mem_q[word_index(aw_addr_d)] <= w_merged;
  end

  // ---------------- outputs ----------------
  always_comb begin
    arready = !reset && (r_state_q == R_IDLE);
    rvalid  = !reset && (r_state_q == R_RESP);
    awready = !reset && (w_state_q == W_IDLE) && !aw_got_q;
    wready  = !reset && (w_state_q == W_IDLE) && !w_got_q;
    bvalid  = !reset && (w_state_q == W_RESP);
    rdata   = rdata_q;
    rresp   = rresp_q;
    bresp   = bresp_q;
  end

endmodule
